// File: rtl/mask_pop_first_unit.sv
`default_nettype none
// ============================================================================
// Module      : mask_pop_first_unit
// Description : Multi-beat mask reduction for the vector core. It consumes a
//               mask register of up to MAX_VL bits, DATA_WIDTH bits per beat,
//               over a valid/ready stream. In a single pass it produces the
//               population count (vcpop.m) and the index of the lowest active
//               set element (vfirst.m). Each data beat can optionally be ANDed
//               with v0, and elements at or beyond vl are ignored.
// Ports       : clk_i, rst_i        - clock, synchronous active-high reset
//               start_i, vl_i,
//               masked_i            - operation start and its parameters
//               data_valid_i/_ready_o,
//               data_i, mask_i      - beat stream (mask bits plus v0 bits)
//               busy_o, done_o      - status and a one-cycle completion pulse
//               cnt_o, first_found_o,
//               first_idx_o         - results; these hold until the next start
// Options     : MASK_POP_PIPE_EN    - registers the per-beat popcount and
//                                     first-set result before the accumulator.
//                                     This adds one cycle of done_o latency.
// Revision    : 1.0 - initial release
// ============================================================================
module mask_pop_first_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_VL     = 256,
    parameter int CNT_W      = $clog2(MAX_VL) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [CNT_W-1:0]      vl_i,
    input  logic                  masked_i,
    input  logic                  data_valid_i,
    output logic                  data_ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [DATA_WIDTH-1:0] mask_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_W-1:0]      cnt_o,
    output logic                  first_found_o,
    output logic [CNT_W-1:0]      first_idx_o
);

    localparam int c_POP_W = $clog2(DATA_WIDTH) + 1;
    localparam int c_IDX_W = $clog2(DATA_WIDTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;
`ifdef MASK_POP_PIPE_EN
    localparam logic [1:0] c_ST_DPEND = 2'd3;
`endif

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_vl_eff;
    logic             r_masked;
    logic [CNT_W-1:0] r_base;      // element index of bit 0 of the current beat
    logic [CNT_W-1:0] r_cnt;
    logic             r_found;
    logic [CNT_W-1:0] r_idx;
    logic             r_done;

    logic [DATA_WIDTH-1:0] w_eff;
    logic [c_POP_W-1:0]    w_pop;
    logic [c_IDX_W-1:0]    w_low;
    logic                  w_any;
    logic                  w_last;
    logic                  w_accept;
    logic [CNT_W-1:0]      w_first_idx;
    logic [CNT_W-1:0]      w_vl_eff;

    // Signals that feed the accumulator, taken either directly from the
    // current beat or from the optional pipeline register.
    logic                  w_acc_en;
    logic [c_POP_W-1:0]    w_acc_pop;
    logic                  w_acc_any;
    logic [CNT_W-1:0]      w_acc_idx;

    assign w_accept = data_valid_i && (r_state == c_ST_RUN);
    assign w_vl_eff = (vl_i > CNT_W'(MAX_VL)) ? CNT_W'(MAX_VL) : vl_i;

    // One extra bit so that base + DATA_WIDTH cannot wrap on the final beat.
    assign w_last = ({1'b0, r_base} + (CNT_W+1)'(DATA_WIDTH)) >= {1'b0, r_vl_eff};

    always_comb begin
        w_eff = '0;
        w_pop = '0;
        w_low = '0;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            w_eff[j] = data_i[j]
                     & (r_masked ? mask_i[j] : 1'b1)
                     & (({1'b0, r_base} + (CNT_W+1)'(j)) < {1'b0, r_vl_eff});
        end
        for (int j = 0; j < DATA_WIDTH; j++) begin
            w_pop = w_pop + c_POP_W'(w_eff[j]);
        end
        // Scan from the top so that the lowest set bit is assigned last.
        for (int j = DATA_WIDTH - 1; j >= 0; j--) begin
            if (w_eff[j]) begin
                w_low = c_IDX_W'(j);
            end
        end
    end

    assign w_any       = |w_eff;
    assign w_first_idx = r_base + CNT_W'(w_low);

`ifdef MASK_POP_PIPE_EN
    logic               r_p_valid;
    logic [c_POP_W-1:0] r_p_pop;
    logic               r_p_any;
    logic [CNT_W-1:0]   r_p_idx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_p_valid <= 1'b0;
            r_p_pop   <= '0;
            r_p_any   <= 1'b0;
            r_p_idx   <= '0;
        end else begin
            r_p_valid <= w_accept;
            if (w_accept) begin
                r_p_pop <= w_pop;
                r_p_any <= w_any;
                r_p_idx <= w_first_idx;
            end
        end
    end

    assign w_acc_en  = r_p_valid;
    assign w_acc_pop = r_p_pop;
    assign w_acc_any = r_p_any;
    assign w_acc_idx = r_p_idx;
`else
    assign w_acc_en  = w_accept;
    assign w_acc_pop = w_pop;
    assign w_acc_any = w_any;
    assign w_acc_idx = w_first_idx;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= c_ST_IDLE;
            r_vl_eff <= '0;
            r_masked <= 1'b0;
            r_base   <= '0;
            r_cnt    <= '0;
            r_found  <= 1'b0;
            r_idx    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Beats reach the accumulator in order, so the first beat with an
            // active set bit wins. Later beats never overwrite the index.
            if (w_acc_en) begin
                r_cnt <= r_cnt + CNT_W'(w_acc_pop);
                if (!r_found && w_acc_any) begin
                    r_found <= 1'b1;
                    r_idx   <= w_acc_idx;
                end
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (start_i) begin
                        r_vl_eff <= w_vl_eff;
                        r_masked <= masked_i;
                        r_base   <= '0;
                        r_cnt    <= '0;
                        r_found  <= 1'b0;
                        r_idx    <= '0;
                        if (w_vl_eff == '0) begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_ST_RUN;
                        end
                    end
                end
                c_ST_RUN: begin
                    if (w_accept) begin
                        r_base <= r_base + CNT_W'(DATA_WIDTH);
                        if (w_last) begin
`ifdef MASK_POP_PIPE_EN
                            r_state <= c_ST_DPEND;
`else
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef MASK_POP_PIPE_EN
                // The final beat is still in the pipeline register here. It is
                // accumulated this cycle, so the results are ready with done_o.
                c_ST_DPEND: begin
                    r_state <= c_ST_DONE;
                    r_done  <= 1'b1;
                end
`endif
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign data_ready_o  = (r_state == c_ST_RUN);
    assign busy_o        = (r_state != c_ST_IDLE);
    assign done_o        = r_done;
    assign cnt_o         = r_cnt;
    assign first_found_o = r_found;
    assign first_idx_o   = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_mask_pop_first_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mask_pop_first_unit
// Description : Directed self-checking bench for mask_pop_first_unit with
//               DATA_WIDTH=32 and MAX_VL=256. Expected values are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mask_pop_first_unit;

    localparam int DW = 32;
    localparam int MVL = 256;
    localparam int CW = 9;
`ifdef MASK_POP_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [CW-1:0] vl_i;
    logic          masked_i;
    logic          data_valid_i;
    logic          data_ready_o;
    logic [DW-1:0] data_i;
    logic [DW-1:0] mask_i;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] cnt_o;
    logic          first_found_o;
    logic [CW-1:0] first_idx_o;

    int checks = 0;
    int errors = 0;
    int acc;
    int lat;
    bit saw_done;
    logic [DW-1:0] bd [0:15];
    logic [DW-1:0] bm [0:15];

    always #5 clk = ~clk;

    mask_pop_first_unit #(
        .DATA_WIDTH (DW),
        .MAX_VL     (MVL),
        .CNT_W      (CW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .vl_i          (vl_i),
        .masked_i      (masked_i),
        .data_valid_i  (data_valid_i),
        .data_ready_o  (data_ready_o),
        .data_i        (data_i),
        .mask_i        (mask_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .cnt_o         (cnt_o),
        .first_found_o (first_found_o),
        .first_idx_o   (first_idx_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input int vl, input bit msk);
        @(negedge clk);
        start_i  = 1'b1;
        vl_i     = CW'(vl);
        masked_i = msk;
        @(negedge clk);
        start_i  = 1'b0;
    endtask

    // Streams beats and counts the handshakes. Returns at the negedge where
    // done_o is first seen. lat_o is the number of cycles from the last
    // accepted beat (or from start, if no beat was taken) to done_o.
    task automatic feed(input int nbeats, input bit toggle, output int acc_o, output int lat_o);
        int idx = 0;
        int last = -1;
        bit seen = 1'b0;
        bit w;
        acc_o = 0;
        lat_o = -1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (done_o) begin
                lat_o = cyc - last;
                seen  = 1'b1;
                break;
            end
            data_valid_i = (idx < nbeats) && (!toggle || (cyc % 2 == 0));
            data_i       = bd[idx % 16];
            mask_i       = bm[idx % 16];
            w            = data_valid_i && data_ready_o;
            @(negedge clk);
            if (w) begin
                idx++;
                acc_o++;
                last = cyc;
            end
        end
        data_valid_i = 1'b0;
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_res(input string tag, input int a_exp, input int c_exp,
                           input bit f_exp, input int i_exp, input int l_exp);
        chk({tag, "_beats"}, acc, a_exp);
        chk({tag, "_cnt"}, cnt_o, c_exp);
        chk({tag, "_found"}, first_found_o, f_exp);
        chk({tag, "_idx"}, first_idx_o, i_exp);
        chk({tag, "_lat"}, lat, l_exp);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done_o, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; start_i = 1'b0; vl_i = '0; masked_i = 1'b0;
        data_valid_i = 1'b0; data_i = '0; mask_i = '0;
        for (int k = 0; k < 16; k++) begin bd[k] = '0; bm[k] = '0; end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", data_ready_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_cnt", cnt_o, 0);
        chk("rst_found", first_found_o, 0);
        chk("rst_idx", first_idx_o, 0);
        rst_i = 1'b0;

        // Scenario 1: two back-to-back beats with an unmasked full vl.
        bd[0] = 32'h0000_0100; bd[1] = 32'hFFFF_FFFF;
        start_op(64, 1'b0);
        chk("s1_busy", busy_o, 1);
        chk("s1_ready", data_ready_o, 1);
        feed(2, 1'b0, acc, lat);
        chk_res("s1", 2, 33, 1'b1, 8, LAT);

        // data_valid_i while IDLE: ignored, and the results hold.
        for (int k = 0; k < 3; k++) begin
            data_valid_i = 1'b1; data_i = 32'hFFFF_FFFF;
            @(negedge clk);
        end
        chk("idle_ready", data_ready_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("idle_hold_cnt", cnt_o, 33);
        chk("idle_hold_idx", first_idx_o, 8);
        data_valid_i = 1'b0;

        // Scenario 2: tail bits 40..63 ignored.
        bd[0] = 32'h0; bd[1] = 32'hFFFF_FFFF;
        start_op(40, 1'b0);
        feed(2, 1'b0, acc, lat);
        chk_res("s2", 2, 8, 1'b1, 32, LAT);

        // Scenario 3: v0 masking, then the same data unmasked.
        bd[0] = 32'hFFFF_FFFF; bm[0] = 32'hF0F0_0000;
        start_op(32, 1'b1);
        feed(1, 1'b0, acc, lat);
        chk_res("s3m", 1, 8, 1'b1, 20, LAT);
        start_op(32, 1'b0);
        feed(1, 1'b0, acc, lat);
        chk_res("s3u", 1, 32, 1'b1, 0, LAT);

        // Scenario 4: vl=0 completes with no beats; vl=300 clamps to 8 beats.
        start_op(0, 1'b0);
        feed(4, 1'b0, acc, lat);
        chk_res("s4z", 0, 0, 1'b0, 0, 1);
        for (int k = 0; k < 16; k++) begin bd[k] = 32'hFFFF_FFFF; bm[k] = '0; end
        start_op(300, 1'b0);
        feed(10, 1'b0, acc, lat);
        chk_res("s4c", 8, 256, 1'b1, 0, LAT);

        // Scenario 5: stalls on every other cycle, with all-zero data.
        for (int k = 0; k < 16; k++) bd[k] = '0;
        start_op(96, 1'b0);
        feed(3, 1'b1, acc, lat);
        chk_res("s5", 3, 0, 1'b0, 0, LAT);

        // Reset asserted mid-operation after one beat of all ones.
        start_op(96, 1'b0);
        data_valid_i = 1'b1; data_i = 32'hFFFF_FFFF; mask_i = '0;
        @(negedge clk);
        data_valid_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("mrst_busy", busy_o, 0);
        chk("mrst_ready", data_ready_o, 0);
        chk("mrst_cnt", cnt_o, 0);
        chk("mrst_found", first_found_o, 0);
        chk("mrst_idx", first_idx_o, 0);
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            saw_done = saw_done | done_o;
            @(negedge clk);
        end
        chk("mrst_no_done", saw_done, 0);

        // Scenario 6: start in DONE is ignored; a start in the next IDLE
        // cycle begins a fresh operation with cleared accumulators.
        bd[0] = 32'hFFFF_FFFF;
        start_op(32, 1'b0);
        feed(1, 1'b0, acc, lat);
        chk("s6a_cnt", cnt_o, 32);
        chk("s6a_lat", lat, LAT);
        start_i = 1'b1; vl_i = CW'(64); masked_i = 1'b0;
        @(negedge clk);
        chk("s6_done_start_ignored", busy_o, 0);
        chk("s6_done_low", done_o, 0);
        @(negedge clk);
        start_i = 1'b0;
        chk("s6_restart_busy", busy_o, 1);
        chk("s6_cleared_cnt", cnt_o, 0);
        chk("s6_cleared_found", first_found_o, 0);
        bd[0] = 32'h0; bd[1] = 32'h8000_0000;
        feed(2, 1'b0, acc, lat);
        chk_res("s6b", 2, 1, 1'b1, 63, LAT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mask_pop_first_unit.md
Name: mask_pop_first_unit

Overview:
Multi-beat mask reduction unit for the vector core. It consumes a mask register of up to MAX_VL bits, DATA_WIDTH bits per beat over a valid/ready stream. It produces the population count (vcpop.m) and the index of the first set element (vfirst.m) in a single pass. It supports an optional v0 mask and tail masking by vl, and sits beside the mask/permute path feeding the scalar writeback.

Parameters:
DATA_WIDTH, 32, mask bits consumed per beat (power of 2, >=2)
MAX_VL, 256, maximum vector length in elements (multiple of DATA_WIDTH)
CNT_W, $clog2(MAX_VL)+1, width of count/index/vl fields

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
start_i  in  1  start pulse; sampled only in IDLE
vl_i  in  CNT_W  vector length for this operation; sampled with start_i
masked_i  in  1  1: AND each data beat with mask_i; sampled with start_i
data_valid_i  in  1  data beat valid
data_ready_o  out  1  unit accepts a beat this cycle
data_i  in  DATA_WIDTH  mask source bits; bit j of beat b = element b*DATA_WIDTH+j
mask_i  in  DATA_WIDTH  v0 bits aligned with data_i; used only when masked
busy_o  out  1  unit not IDLE
done_o  out  1  one-cycle pulse when results are valid
cnt_o  out  CNT_W  number of active set elements
first_found_o  out  1  at least one active set element exists
first_idx_o  out  CNT_W  lowest active set element index; 0 when not found

Behaviour:
- Reset (rst_i=1 at clock edge, any state): state IDLE, data_ready_o=0, busy_o=0, done_o=0, cnt_o=0, first_found_o=0, first_idx_o=0, beat counter=0. Reset mid-operation abandons the operation; no done_o is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_i=1: latch vl_eff = min(vl_i, MAX_VL) and masked_i; clear the accumulators and beat counter.
  - If vl_eff==0, go to DONE. Otherwise go to RUN.
  - Results from the previous operation hold until start_i.
- RUN:
  - data_ready_o=1. A beat is accepted when data_valid_i && data_ready_o.
  - With base = beat*DATA_WIDTH, effective bits are eff[j] = data_i[j] & (masked ? mask_i[j] : 1) & (base+j < vl_eff).
  - On each accepted beat:
    - cnt += popcount(eff).
    - If !first_found and eff != 0: first_found=1 and first_idx = base + index of the lowest set bit of eff.
    - A later beat never overwrites first_idx.
  - Last beat is the one where base+DATA_WIDTH >= vl_eff. After accepting it, go to DONE. No further beats are accepted.
  - Cycles with data_valid_i=0 stall with no state change. Throughput is one beat per cycle.
- DONE:
  - done_o=1 for exactly one cycle, then IDLE. data_ready_o=0.
  - start_i asserted in DONE is ignored.
- Latency: done_o is asserted in the cycle after the last beat is accepted; cnt_o and first_* are valid in that same cycle.
- Width rules:
  - cnt_o never exceeds vl_eff <= MAX_VL and therefore fits CNT_W.
  - Popcount per beat is $clog2(DATA_WIDTH)+1 bits, zero-extended.
- Boundaries:
  - vl_i > MAX_VL is clamped.
  - vl not a multiple of DATA_WIDTH: the tail bits of the final beat are ignored.
  - A full beat of all ones gives popcount DATA_WIDTH.
  - data_valid_i while IDLE/DONE is ignored, with no stall and no side effect.

Optional Feature:
MASK_POP_PIPE_EN
- Defined: the per-beat popcount and first-set detection results are registered before the accumulator (one extra stage).
  - Throughput is unchanged.
  - done_o moves to 2 cycles after the last accepted beat.
  - The FSM waits one cycle in DONE-pending before pulsing done_o.
  - A reset clears the pipeline register.
- Undefined: single-stage path as described above; latency is 1.

Test Plan:
1. DATA_WIDTH=32, vl=64, masked=0, beats 0x0000_0100 then 0xFFFF_FFFF, back-to-back valid -> cnt_o=33, first_found_o=1, first_idx_o=8, done_o one cycle after 2nd beat.
2. vl=40, beats 0x0000_0000 then 0xFFFF_FFFF -> tail bits 40..63 ignored; cnt_o=8, first_idx_o=32.
3. masked=1, vl=32, data=0xFFFF_FFFF, mask=0xF0F0_0000 -> cnt_o=8, first_idx_o=20; with masked=0, same data -> cnt_o=32, first_idx_o=0.
4. vl=0 start -> done_o in the next cycle with no beats accepted, cnt_o=0, first_found_o=0. vl=300 with MAX_VL=256 -> exactly 8 beats accepted.
5. vl=96, data_valid_i toggling 1/0 every cycle, all-zero data -> 3 beats accepted over 5+ cycles, cnt_o=0, first_found_o=0. Repeat with rst_i asserted after beat 1 -> IDLE, all outputs 0, no done_o.
6. Under MASK_POP_PIPE_EN, rerun scenario 1 -> same results, done_o 2 cycles after the last beat. start_i in DONE ignored; a new start in the following IDLE cycle begins a fresh operation with cleared accumulators.
